// File: rtl/idu_stage.sv
// idu_stage: RV32I decode stage sitting directly behind the fetch unit.
//
// Accepts {pc, inst} from fetch over a valid/ready handshake and holds it in a
// two-slot skid buffer (main + skid). The main slot is decoded combinationally
// and presented to execute over a second valid/ready handshake. There is no
// combinational path from any in_* input to any out_* output or to in_ready.
//
// Handshake rule (both interfaces): a transfer happens on a rising clk edge
// where valid && ready are both 1. A producer holding valid=1 keeps its payload
// stable until the transfer. in_ready is a pure function of flop state
// (!skid_valid), so it never depends on in_valid in the same cycle.
//
// Optional feature: define IDU_PERF_EN to build the perf_issued / perf_stall
// counters. Without it the ports remain and are tied to zero.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous drop of both slots (redirect)
//   in_valid/in_ready     fetch handshake; in_pc, in_inst payload
//   out_valid/out_ready   execute handshake
//   out_pc, out_inst      main slot contents
//   out_rs1/rs2/rd        register fields of the main slot instruction
//   out_fmt               0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
//   out_imm               sign-extended immediate (0 for R/illegal)
//   out_illegal           unsupported opcode
//   perf_issued           out handshakes since reset
//   perf_stall            cycles with out_valid && !out_ready since reset
module idu_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_fmt,
  output logic [31:0]     out_imm,
  output logic            out_illegal,
  output logic [31:0]     perf_issued,
  output logic [31:0]     perf_stall
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  logic            main_valid;
  logic [XLEN-1:0] main_pc;
  logic [31:0]     main_inst;
  logic            skid_valid;
  logic [XLEN-1:0] skid_pc;
  logic [31:0]     skid_inst;

  logic in_fire;
  logic out_fire;

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Slot update. Flush wins over everything, including a same-cycle in_fire.
  // When main drains (or is empty) the skid entry moves up first so order is
  // preserved; a new word can only land in skid while main is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_pc    <= '0;
      main_inst  <= '0;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_inst  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_fire) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_pc    <= skid_pc;
        main_inst  <= skid_inst;
      end else if (in_fire) begin
        main_valid <= 1'b1;
        main_pc    <= in_pc;
        main_inst  <= in_inst;
      end else begin
        main_valid <= 1'b0;
      end
      // in_fire implies skid was empty, so this only captures when both
      // happen together (never, given in_ready = !skid_valid) -- kept explicit.
      if (skid_valid && in_fire) begin
        skid_valid <= 1'b1;
        skid_pc    <= in_pc;
        skid_inst  <= in_inst;
      end else begin
        skid_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_pc    <= in_pc;
      skid_inst  <= in_inst;
    end
  end

  // Decode of the main slot.
  logic [4:0] opcode;
  assign opcode = main_inst[6:2];

  always_comb begin
    out_fmt = FMT_ILL;
    if (main_inst[1:0] == 2'b11) begin
      case (opcode)
        5'b01100:                            out_fmt = FMT_R;
        5'b00100, 5'b00000, 5'b11001, 5'b11100: out_fmt = FMT_I;
        5'b01000:                            out_fmt = FMT_S;
        5'b11000:                            out_fmt = FMT_B;
        5'b01101, 5'b00101:                  out_fmt = FMT_U;
        5'b11011:                            out_fmt = FMT_J;
        default:                             out_fmt = FMT_ILL;
      endcase
    end
  end

  always_comb begin
    out_imm = 32'h0;
    case (out_fmt)
      FMT_I: out_imm = {{20{main_inst[31]}}, main_inst[31:20]};
      FMT_S: out_imm = {{20{main_inst[31]}}, main_inst[31:25], main_inst[11:7]};
      FMT_B: out_imm = {{19{main_inst[31]}}, main_inst[31], main_inst[7],
                        main_inst[30:25], main_inst[11:8], 1'b0};
      FMT_U: out_imm = {main_inst[31:12], 12'b0};
      FMT_J: out_imm = {{11{main_inst[31]}}, main_inst[31], main_inst[19:12],
                        main_inst[20], main_inst[30:21], 1'b0};
      default: out_imm = 32'h0;
    endcase
  end

  assign out_illegal = (out_fmt == FMT_ILL);
  assign out_pc      = main_pc;
  assign out_inst    = main_inst;
  assign out_rs1     = main_inst[19:15];
  assign out_rs2     = main_inst[24:20];
  assign out_rd      = main_inst[11:7];

`ifdef IDU_PERF_EN
  // Counters wrap naturally; flush does not clear them, and a handshake in a
  // flush cycle still counts as issued.
  logic [31:0] issued_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q <= 32'h0;
      stall_q  <= 32'h0;
    end else begin
      if (out_fire) issued_q <= issued_q + 32'h1;
      if (out_valid && !out_ready) stall_q <= stall_q + 32'h1;
    end
  end

  assign perf_issued = issued_q;
  assign perf_stall  = stall_q;
`else
  assign perf_issued = 32'h0;
  assign perf_stall  = 32'h0;
`endif

endmodule

// File: tb/tb_idu_stage.sv
module tb_idu_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [2:0]  out_fmt;
  logic [31:0] out_imm;
  logic        out_illegal;
  logic [31:0] perf_issued;
  logic [31:0] perf_stall;

  int total;
  int bad;

  logic [31:0] exp_q[$];

  idu_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_inst     (in_inst),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_rd      (out_rd),
    .out_fmt     (out_fmt),
    .out_imm     (out_imm),
    .out_illegal (out_illegal),
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = 32'h0;
    in_inst   = 32'h0;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_in(input logic [31:0] pc, input logic [31:0] inst);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0;
    in_pc    = 32'h0;
    in_inst  = 32'h0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    // Fill both slots, then assert reset asynchronously between edges.
    out_ready = 1'b0;
    drive_in(32'h100, 32'h00500093);
    step();
    drive_in(32'h104, 32'h00500093);
    step();
    drive_idle();
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_prefill_ready got=%b exp=%b", in_ready, 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_async got out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
    end
    total++;
    if (out_pc !== 32'h0 || out_inst !== 32'h0 || perf_issued !== 32'h0 || perf_stall !== 32'h0) begin
      bad++;
      $display("FAIL reset_data got pc=%h inst=%h iss=%h stl=%h exp all 0",
               out_pc, out_inst, perf_issued, perf_stall);
    end
    step();
    rst_n = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release got out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    drive_in(32'h80000000, 32'h00500093);
    step();
    drive_idle();
    total++;
    if (out_valid !== 1'b1 || out_fmt !== 3'd1 || out_rd !== 5'd1 || out_rs1 !== 5'd0 ||
        out_imm !== 32'h5 || out_pc !== 32'h80000000 || out_illegal !== 1'b0) begin
      bad++;
      $display("FAIL addi got v=%b fmt=%0d rd=%0d rs1=%0d imm=%h pc=%h ill=%b exp 1 1 1 0 00000005 80000000 0",
               out_valid, out_fmt, out_rd, out_rs1, out_imm, out_pc, out_illegal);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL addi_drain got out_valid=%b exp 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic fire;
    int   guard;
    logic [31:0] exp_pc;
    out_ready = 1'b0;
    exp_q.delete();
    drive_in(32'h200, 32'h00100113); exp_q.push_back(32'h200);
    step();
    drive_in(32'h204, 32'h00200113); exp_q.push_back(32'h204);
    step();
    total++;
    if (in_ready !== 1'b0 || out_pc !== 32'h200) begin
      bad++;
      $display("FAIL bp_full got in_ready=%b pc=%h exp 0 00000200", in_ready, out_pc);
    end
    drive_in(32'h208, 32'h00300113); exp_q.push_back(32'h208);
    step();
    total++;
    if (in_ready !== 1'b0 || out_pc !== 32'h200 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_hold got in_ready=%b pc=%h v=%b exp 0 00000200 1", in_ready, out_pc, out_valid);
    end
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      if (out_valid) begin
        exp_pc = exp_q.pop_front();
        total++;
        if (out_pc !== exp_pc) begin
          bad++;
          $display("FAIL bp_order got pc=%h exp=%h", out_pc, exp_pc);
        end
      end
      fire = in_valid && in_ready;
      step();
      if (fire) drive_idle();
      guard++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL bp_timeout got left=%0d exp 0", exp_q.size());
    end
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_empty got v=%b in_ready=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } vec_t;

  // Decode table pushed back-to-back with out_ready=1: every cycle must fire.
  task automatic test_back_to_back();
    vec_t v[7];
    v[0] = '{32'hFE208EE3, 3'd3, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd29}; // beq x1,x2,-4
    v[1] = '{32'h002081B3, 3'd0, 32'h00000000, 5'd1, 5'd2, 5'd3};  // add x3,x1,x2
    v[2] = '{32'h0020A623, 3'd2, 32'h0000000C, 5'd1, 5'd2, 5'd12}; // sw x2,12(x1)
    v[3] = '{32'h123452B7, 3'd4, 32'h12345000, 5'd8, 5'd3, 5'd5};  // lui x5,0x12345
    v[4] = '{32'h0080006F, 3'd5, 32'h00000008, 5'd0, 5'd8, 5'd0};  // jal x0,8
    v[5] = '{32'hFFF00093, 3'd1, 32'hFFFFFFFF, 5'd0, 5'd31, 5'd1}; // addi x1,x0,-1
    v[6] = '{32'h00500091, 3'd7, 32'h00000000, 5'd0, 5'd5, 5'd1};  // bad low bits
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b_ready[%0d] got=%b exp=1", i, in_ready);
      end
      drive_in(32'h300 + 32'(i * 4), v[i].inst);
      step();
      total++;
      if (out_valid !== 1'b1 || out_pc !== 32'h300 + 32'(i * 4) || out_fmt !== v[i].fmt ||
          out_imm !== v[i].imm || out_rs1 !== v[i].rs1 || out_rs2 !== v[i].rs2 ||
          out_rd !== v[i].rd || out_illegal !== (v[i].fmt == 3'd7)) begin
        bad++;
        $display("FAIL b2b_decode[%0d] got v=%b pc=%h fmt=%0d imm=%h rs1=%0d rs2=%0d rd=%0d ill=%b exp fmt=%0d imm=%h rs1=%0d rs2=%0d rd=%0d",
                 i, out_valid, out_pc, out_fmt, out_imm, out_rs1, out_rs2, out_rd, out_illegal,
                 v[i].fmt, v[i].imm, v[i].rs1, v[i].rs2, v[i].rd);
      end
    end
    drive_idle();
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive_in(32'h400, 32'h00100113);
    step();
    drive_in(32'h404, 32'h00200113);
    step();
    drive_in(32'h408, 32'h00300113);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive_idle();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush got v=%b in_ready=%b exp 0 1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL flush_no_output[%0d] got v=%b pc=%h exp v=0", i, out_valid, out_pc);
      end
    end
  endtask

  task automatic test_illegal_perf();
    do_reset();
    out_ready = 1'b0;
    drive_in(32'h500, 32'h00000000);
    step();
    drive_idle();
    total++;
    if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_fmt !== 3'd7 || out_imm !== 32'h0) begin
      bad++;
      $display("FAIL illegal got v=%b ill=%b fmt=%0d imm=%h exp 1 1 7 0",
               out_valid, out_illegal, out_fmt, out_imm);
    end
    step();
    step();
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
`ifdef IDU_PERF_EN
    total++;
    if (perf_stall !== 32'd3 || perf_issued !== 32'd1) begin
      bad++;
      $display("FAIL perf got stall=%0d issued=%0d exp 3 1", perf_stall, perf_issued);
    end
`else
    total++;
    if (perf_stall !== 32'd0 || perf_issued !== 32'd0) begin
      bad++;
      $display("FAIL perf_tied got stall=%0d issued=%0d exp 0 0", perf_stall, perf_issued);
    end
`endif
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL illegal_drain got v=%b exp 0", out_valid);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    total = 0;
    bad   = 0;
    do_reset();
    test_reset();
    test_addi();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_illegal_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
